// File: rtl/wb_arbiter.sv
// Write-back arbiter: the ALU has absolute priority on the register file write port; LSU results bypass or queue in an in-order FIFO.
// Optional feature macro WB_PARITY_EN adds per-entry even parity and a sticky par_err.
module wb_arbiter #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic                       alu_we,
    input  logic [ADDR_W-1:0]          alu_rd,
    input  logic [DATA_W-1:0]          alu_data,
    input  logic                       lsu_valid,
    output logic                       lsu_ready,
    input  logic [ADDR_W-1:0]          lsu_rd,
    input  logic [DATA_W-1:0]          lsu_data,
    output logic                       write_enable,
    output logic [ADDR_W-1:0]          write_addr,
    output logic [DATA_W-1:0]          write_data,
    output logic [(2**ADDR_W)-1:0]     pend_mask,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       par_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [ADDR_W-1:0] rd_q    [DEPTH];
    logic [ADDR_W-1:0] rd_d    [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [DATA_W-1:0] data_d  [DEPTH];
    logic              stale_q [DEPTH];
    logic              stale_d [DEPTH];
    logic              valid_q [DEPTH];
    logic              valid_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    logic alu_act, accept, fifo_empty, head_stale, head_par_ok;
    logic pop, push, bypass, we_c;

`ifdef WB_PARITY_EN
    logic par_q [DEPTH];
    logic par_d [DEPTH];
    logic par_err_q, par_err_d;
    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

    assign fifo_count   = count_q;
    assign write_enable = we_c && rstN;

    always_comb begin
        alu_act     = alu_we && (alu_rd != '0);
        lsu_ready   = rstN && (count_q < DEPTH_C);
        accept      = lsu_valid && lsu_ready;
        fifo_empty  = (count_q == '0);
        head_stale  = stale_q[rd_ptr_q];
`ifdef WB_PARITY_EN
        head_par_ok = ((^{rd_q[rd_ptr_q], data_q[rd_ptr_q]}) == par_q[rd_ptr_q]);
        par_err_d   = par_err_q;
        par_d       = par_q;
`else
        head_par_ok = 1'b1;
`endif
        bypass     = 1'b0;
        we_c       = 1'b0;
        write_addr = '0;
        write_data = '0;
        rd_d       = rd_q;
        data_d     = data_q;
        stale_d    = stale_q;
        valid_d    = valid_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (alu_act) begin
            we_c       = 1'b1;
            write_addr = alu_rd;
            write_data = alu_data;
        end else if (!fifo_empty) begin
            if (!head_stale && head_par_ok) begin
                we_c       = 1'b1;
                write_addr = rd_q[rd_ptr_q];
                write_data = data_q[rd_ptr_q];
            end
        end else if (accept && (lsu_rd != '0)) begin
            bypass     = 1'b1;
            we_c       = 1'b1;
            write_addr = lsu_rd;
            write_data = lsu_data;
        end

        pop  = !fifo_empty && (head_stale || !alu_act);
        push = accept && (lsu_rd != '0) && !bypass;

`ifdef WB_PARITY_EN
        if (pop && !alu_act && !head_stale && !head_par_ok)
            par_err_d = 1'b1;
`endif

        // An ALU write supersedes any older queued result for the same register.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (alu_act && valid_q[i] && (rd_q[i] == alu_rd))
                stale_d[i] = 1'b1;
        end

        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PW'(1);
        end

        if (push) begin
            valid_d[wr_ptr_q] = 1'b1;
            rd_d[wr_ptr_q]    = lsu_rd;
            data_d[wr_ptr_q]  = lsu_data;
            stale_d[wr_ptr_q] = alu_act && (alu_rd == lsu_rd);
`ifdef WB_PARITY_EN
            par_d[wr_ptr_q]   = ^{lsu_rd, lsu_data};
`endif
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        pend_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && !stale_q[i])
                pend_mask[rd_q[i]] = 1'b1;
        end
        pend_mask[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rd_q[i]    <= '0;
                data_q[i]  <= '0;
                stale_q[i] <= 1'b0;
                valid_q[i] <= 1'b0;
`ifdef WB_PARITY_EN
                par_q[i]   <= 1'b0;
`endif
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
`ifdef WB_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            rd_q      <= rd_d;
            data_q    <= data_d;
            stale_q   <= stale_d;
            valid_q   <= valid_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
`ifdef WB_PARITY_EN
            par_q     <= par_d;
            par_err_q <= par_err_d;
`endif
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (DEPTH=4, DATA_W=32, ADDR_W=5).
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        rstN;
    logic        alu_we;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [31:0] pend_mask;
    logic [2:0]  fifo_count;
    logic        par_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rstN(rstN),
        .alu_we(alu_we), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .pend_mask(pend_mask), .fifo_count(fifo_count), .par_err(par_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs at the falling edge, then let combinational outputs settle.
    task automatic drive(input logic aw, input logic [4:0] ard, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        @(negedge clk);
        alu_we = aw; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic chk_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
        chk({tag, "_we"}, 64'(write_enable), 64'd1);
        chk({tag, "_addr"}, 64'(write_addr), 64'(a));
        chk({tag, "_data"}, 64'(write_data), 64'(d));
    endtask

    initial begin
        rstN = 1'b0;
        alu_we = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        lsu_valid = 1'b1; lsu_rd = 5'd5; lsu_data = 32'h55;
        #12;
        chk("rst_ready_forced", 64'(lsu_ready), 64'd0);
        chk("rst_we_forced", 64'(write_enable), 64'd0);
        idle();
        rstN = 1'b1;
        #1;
        chk("rst_ready", 64'(lsu_ready), 64'd1);
        chk("rst_we", 64'(write_enable), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_pend", 64'(pend_mask), 64'd0);
        chk("rst_par", 64'(par_err), 64'd0);

        // Bypass: FIFO empty, ALU idle
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF);
        chk_wr("bypass", 5'd5, 32'hDEADBEEF);
        idle();
        chk("bypass_count", 64'(fifo_count), 64'd0);

        // Conflict: ALU owns port while LSU pushes 7,8,9
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h70);
        chk_wr("conf_alu0", 5'd3, 32'h33);
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd8, 32'h80);
        chk_wr("conf_alu1", 5'd3, 32'h33);
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h90);
        chk_wr("conf_alu2", 5'd3, 32'h33);
        idle();
        chk("conf_count", 64'(fifo_count), 64'd3);
        chk("conf_pend", 64'(pend_mask), 64'h380);
        chk_wr("drain7", 5'd7, 32'h70);
        idle();
        chk_wr("drain8", 5'd8, 32'h80);
        chk("drain8_count", 64'(fifo_count), 64'd2);
        idle();
        chk_wr("drain9", 5'd9, 32'h90);
        idle();
        chk("drained_we", 64'(write_enable), 64'd0);
        chk("drained_count", 64'(fifo_count), 64'd0);
        chk("drained_pend", 64'(pend_mask), 64'd0);

        // Full: 4 pushes under ALU, 5th offer held
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd3, 32'h33, 1'b1, 5'(11 + i), 32'(32'h100 + i));
            chk($sformatf("full_ready%0d", i), 64'(lsu_ready), 64'd1);
        end
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd15, 32'h1F);
        chk("full_ready", 64'(lsu_ready), 64'd0);
        chk("full_count", 64'(fifo_count), 64'd4);
        chk("full_pend", 64'(pend_mask), 64'h7800);
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd15, 32'h1F);
        chk("full_held_count", 64'(fifo_count), 64'd4);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd15, 32'h1F);
        chk("full_pop_ready", 64'(lsu_ready), 64'd0);
        chk_wr("full_pop11", 5'd11, 32'h100);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd15, 32'h1F);
        chk("full_ready_again", 64'(lsu_ready), 64'd1);
        chk_wr("full_pop12", 5'd12, 32'h101);
        idle();
        chk("full_pushpop_count", 64'(fifo_count), 64'd3);
        chk_wr("full_pop13", 5'd13, 32'h102);
        idle();
        chk_wr("full_pop14", 5'd14, 32'h103);
        idle();
        chk_wr("full_pop15", 5'd15, 32'h1F);
        idle();
        chk("full_empty", 64'(fifo_count), 64'd0);

        // Stale kill: queued rd=10 overwritten by a later ALU write
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd10, 32'hA0);
        drive(1'b1, 5'd10, 32'hAAAA, 1'b0, 5'd0, 32'h0);
        chk("stale_pend_before", 64'(pend_mask), 64'h400);
        chk_wr("stale_alu", 5'd10, 32'hAAAA);
        idle();
        chk("stale_pend_after", 64'(pend_mask), 64'd0);
        chk("stale_count", 64'(fifo_count), 64'd1);
        chk("stale_nowrite", 64'(write_enable), 64'd0);
        idle();
        chk("stale_gone", 64'(fifo_count), 64'd0);

        // Same-cycle ALU/LSU to the same register: pushed entry is already stale
        drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd6, 32'h60);
        chk_wr("same_alu", 5'd6, 32'h66);
        idle();
        chk("same_pend", 64'(pend_mask), 64'd0);
        chk("same_count", 64'(fifo_count), 64'd1);
        chk("same_nowrite", 64'(write_enable), 64'd0);
        idle();
        chk("same_gone", 64'(fifo_count), 64'd0);

        // x0 handling
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234);
        chk("x0_ready", 64'(lsu_ready), 64'd1);
        chk("x0_nowrite", 64'(write_enable), 64'd0);
        drive(1'b1, 5'd0, 32'h77, 1'b0, 5'd0, 32'h0);
        chk("x0_count", 64'(fifo_count), 64'd0);
        chk("alu_x0_nowrite", 64'(write_enable), 64'd0);
        drive(1'b1, 5'd0, 32'h77, 1'b1, 5'd4, 32'h44);
        chk_wr("alu_x0_bypass", 5'd4, 32'h44);
        idle();
        chk("alu_x0_count", 64'(fifo_count), 64'd0);

        // Asynchronous reset mid-cycle clears a queued entry
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd20, 32'h200);
        idle();
        chk("arst_pre_count", 64'(fifo_count), 64'd1);
        #2 rstN = 1'b0;
        #1;
        chk("arst_count", 64'(fifo_count), 64'd0);
        chk("arst_pend", 64'(pend_mask), 64'd0);
        chk("arst_ready", 64'(lsu_ready), 64'd0);
        @(negedge clk);
        rstN = 1'b1;
        #1;
        chk("arst_ready_after", 64'(lsu_ready), 64'd1);

`ifdef WB_PARITY_EN
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd21, 32'h210);
        idle();
        dut.data_q[0][0] = ~dut.data_q[0][0];
        #1;
        chk("par_nowrite", 64'(write_enable), 64'd0);
        idle();
        chk("par_err_set", 64'(par_err), 64'd1);
        chk("par_count", 64'(fifo_count), 64'd0);
        idle();
        chk("par_err_sticky", 64'(par_err), 64'd1);
        rstN = 1'b0;
        #1;
        chk("par_err_cleared", 64'(par_err), 64'd0);
        rstN = 1'b1;
`else
        chk("par_err_tied", 64'(par_err), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
